instruction_decode: RTL and testbench
=====================================

Name: instruction_decode

Overview:
- Decode stage of the 5-stage RV32I pipeline; consumes the IF/ID register (instruction word and PC) produced by the fetch stage.
- Contains the 32x32 register file, the main decoder, the ALU-control decoder and the immediate generator.
- Registers all results into the ID/EX pipeline register for the execute stage.
- Accepts the writeback port from the W stage, and a flush from the hazard unit.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, number of architectural registers; x0 is hardwired to zero.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- IF_ID_IR  in  32  instruction word from the fetch stage.
- IF_ID_PC  in  32  PC of that instruction.
- flush_e  in  1  insert a bubble into ID/EX next edge (branch taken or load-use).
- RegWriteW  in  1  writeback enable.
- RdW  in  5  writeback destination register.
- ResultW  in  32  writeback data.
- ID_EX_RD1, ID_EX_RD2  out  32  rs1 and rs2 operand values.
- ID_EX_Imm  out  32  sign-extended immediate.
- ID_EX_PC  out  32  PC passed through.
- ID_EX_Rs1, ID_EX_Rs2, ID_EX_Rd  out  5 each  register indices, used by the forwarding unit.
- ID_EX_RegWrite, ID_EX_MemWrite, ID_EX_Jump, ID_EX_Branch, ID_EX_ALUSrc, ID_EX_Jalr  out  1 each  control bits.
- ID_EX_ResultSrc  out  2  result select: 00 ALU, 01 memory, 10 PC+4.
- ID_EX_ALUControl  out  4  ALU operation code (package encoding).
- ID_EX_Funct3  out  3  branch condition and load/store size.
- ID_EX_SrcAPC  out  1  ALU source A is the PC (AUIPC).
- illegal_e  out  1  the instruction in ID/EX has an unsupported opcode.

Behaviour:
- Reset: when rst=0 at a clk edge, every ID/EX output and illegal_e becomes 0 (a NOP bubble). All 32 registers are cleared on the same edge.
- Latency: an instruction present on IF_ID_IR/PC at edge N appears on the ID/EX outputs after edge N.
- Register file:
  - Write happens on the clk edge when RegWriteW=1 and RdW!=0.
  - A write with RdW=0 is discarded; a read of x0 always returns 0.
  - Write-through: if RegWriteW=1, RdW!=0 and RdW equals rs1 or rs2 in the same cycle, RD1/RD2 capture ResultW, not the stale value.
- Immediate generation, selected by opcode:
  - I type (OP-IMM, LOAD, JALR): IR[31:20], sign-extended.
  - S type: {IR[31:25], IR[11:7]}, sign-extended.
  - B type: {IR[31], IR[7], IR[30:25], IR[11:8], 0}, sign-extended.
  - U type: {IR[31:12], 12'b0}.
  - J type: {IR[31], IR[19:12], IR[20], IR[30:21], 0}, sign-extended.
  - R type: immediate is 0.
- Decoded opcodes: OP, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
  - LUI: ALUControl=PASSB, ALUSrc=1.
  - AUIPC: SrcAPC=1, ADD.
  - JAL/JALR: Jump=1, ResultSrc=10. JALR additionally sets Jalr=1.
  - BRANCH: Branch=1, ALUControl=SUB.
  - Shifts: SRA/SRAI selected by IR[30]. OP with IR[30]=1 and funct3=000 decodes to SUB; OP-IMM never decodes to SUB.
- Illegal opcode: all control bits 0 (bubble), illegal_e=1 latched with the PC.
- flush_e=1: next edge loads a bubble (all control bits 0, illegal_e=0). Data fields are don't-care but are driven to 0. flush_e has priority over decode.
- Reset has priority over flush_e. Reset asserted mid-stream discards the in-flight instruction.
- No stall input: the hazard unit stalls by holding IF/ID and pulsing flush_e.

Decomposition:
- Package rv32i_pkg:
  - opcode constants.
  - ALU code constants: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRL=8, SRA=9, PASSB=10.
  - ResultSrc constants.
  - Immediate-type constants.
- One sub-module, register_file: 2 read ports, 1 write port, with the write-through logic.
- Decoder and immediate generator live inline in instruction_decode.

Test Plan:
- Reset: rst=0 for 2 edges with IR=0x003180B3 -> all ID_EX outputs 0, illegal_e=0.
- addi x5,x0,-3 (IR=0xFFD00293, PC=0x10) -> Imm=0xFFFFFFFD, Rd=5, ALUSrc=1, RegWrite=1, ALUControl=ADD, PC=0x10, RD1=0.
- Write-through: RegWriteW=1, RdW=3, ResultW=0xDEADBEEF in the same cycle as add x1,x3,x3 (0x003180B3) -> RD1=RD2=0xDEADBEEF, Rd=1, ALUSrc=0.
- x0 protection: RegWriteW=1, RdW=0, ResultW=5, then decode 0x003180B3 with rs=x0 variant (0x000000B3) -> RD1=RD2=0.
- beq x1,x2,-8 (0xFE208CE3) -> Imm=0xFFFFFFF8, Branch=1, ALUControl=SUB, Funct3=000, RegWrite=0.
- flush_e=1 with a valid addi present -> all control outputs 0 next cycle. IR=0x0000007F -> bubble with illegal_e=1.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants: opcodes, ALU codes, result selects, immediate types
// and the ID/EX register layout.
package rv32i_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLTU  = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

    typedef struct packed {
        logic [XLEN_DEF-1:0] rd1;
        logic [XLEN_DEF-1:0] rd2;
        logic [XLEN_DEF-1:0] imm;
        logic [XLEN_DEF-1:0] pc;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic                reg_write;
        logic                mem_write;
        logic                jump;
        logic                branch;
        logic                alu_src;
        logic                jalr;
        logic [1:0]          result_src;
        alu_op_e             alu_ctrl;
        logic [2:0]          funct3;
        logic                src_a_pc;
        logic                illegal;
    } idex_t;

    // alt is IR[30]; allow_sub is false for OP-IMM, where IR[30] is immediate data on ADDI.
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt,
                                            input logic allow_sub);
        alu_op_e op;
        case (f3)
            3'b000:  op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/instruction_decode_register_file.sv
// 32-entry register file, two combinational read ports, one write port.
// Reads bypass a same-cycle write so decode never sees a stale operand; x0 reads as zero.
module register_file
    import rv32i_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      rs1_i,
    input  logic [4:0]      rs2_i,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o,
    input  logic            we_i,
    input  logic [4:0]      wa_i,
    input  logic [XLEN-1:0] wd_i
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic            wr_en;

    assign wr_en = we_i && (wa_i != 5'd0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    always_comb begin
        rd1_o = '0;
        rd2_o = '0;
        if (rs1_i != 5'd0) begin
            rd1_o = (wr_en && (wa_i == rs1_i)) ? wd_i : regs_q[rs1_i];
        end
        if (rs2_i != 5'd0) begin
            rd2_o = (wr_en && (wa_i == rs2_i)) ? wd_i : regs_q[rs2_i];
        end
    end

endmodule

// File: rtl/instruction_decode.sv
// RV32I decode stage: register read, main/ALU decode, immediate generation into ID/EX.
// One-cycle latency; flush_e inserts a bubble, reset outranks flush.
module instruction_decode
    import rv32i_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     IF_ID_IR,
    input  logic [XLEN-1:0] IF_ID_PC,
    input  logic            flush_e,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW,
    input  logic [XLEN-1:0] ResultW,
    output logic [XLEN-1:0] ID_EX_RD1,
    output logic [XLEN-1:0] ID_EX_RD2,
    output logic [XLEN-1:0] ID_EX_Imm,
    output logic [XLEN-1:0] ID_EX_PC,
    output logic [4:0]      ID_EX_Rs1,
    output logic [4:0]      ID_EX_Rs2,
    output logic [4:0]      ID_EX_Rd,
    output logic            ID_EX_RegWrite,
    output logic            ID_EX_MemWrite,
    output logic            ID_EX_Jump,
    output logic            ID_EX_Branch,
    output logic            ID_EX_ALUSrc,
    output logic            ID_EX_Jalr,
    output logic [1:0]      ID_EX_ResultSrc,
    output logic [3:0]      ID_EX_ALUControl,
    output logic [2:0]      ID_EX_Funct3,
    output logic            ID_EX_SrcAPC,
    output logic            illegal_e
);

    logic [31:0]     ir;
    logic [6:0]      opcode;
    logic [XLEN-1:0] rd1, rd2, imm;
    imm_type_e       imm_type;
    idex_t           dec, idex_d, idex_q;

    assign ir     = IF_ID_IR;
    assign opcode = ir[6:0];

    register_file #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
        .clk   (clk),
        .rst   (rst),
        .rs1_i (ir[19:15]),
        .rs2_i (ir[24:20]),
        .rd1_o (rd1),
        .rd2_o (rd2),
        .we_i  (RegWriteW),
        .wa_i  (RdW),
        .wd_i  (ResultW)
    );

    always_comb begin
        imm = '0;
        case (imm_type)
            IMM_I:   imm = {{(XLEN-12){ir[31]}}, ir[31:20]};
            IMM_S:   imm = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   imm = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            IMM_U:   imm = {ir[31:12], 12'b0};
            IMM_J:   imm = {{(XLEN-21){ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    always_comb begin
        dec          = '0;
        imm_type     = IMM_NONE;
        dec.alu_ctrl = ALU_ADD;
        case (opcode)
            OPC_OP: begin
                dec.reg_write = 1'b1;
                dec.alu_ctrl  = alu_from_f3(ir[14:12], ir[30], 1'b1);
            end
            OPC_OP_IMM: begin
                imm_type      = IMM_I;
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_ctrl  = alu_from_f3(ir[14:12], ir[30], 1'b0);
            end
            OPC_LOAD: begin
                imm_type       = IMM_I;
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = RES_MEM;
            end
            OPC_STORE: begin
                imm_type      = IMM_S;
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
            end
            OPC_BRANCH: begin
                imm_type     = IMM_B;
                dec.branch   = 1'b1;
                dec.alu_ctrl = ALU_SUB;
            end
            OPC_JAL: begin
                imm_type       = IMM_J;
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.result_src = RES_PC4;
            end
            OPC_JALR: begin
                imm_type       = IMM_I;
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.jalr       = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = RES_PC4;
            end
            OPC_LUI: begin
                imm_type      = IMM_U;
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_ctrl  = ALU_PASSB;
            end
            OPC_AUIPC: begin
                imm_type      = IMM_U;
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.src_a_pc  = 1'b1;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
        dec.rd1    = rd1;
        dec.rd2    = rd2;
        dec.imm    = imm;
        dec.pc     = IF_ID_PC;
        dec.rs1    = ir[19:15];
        dec.rs2    = ir[24:20];
        dec.rd     = ir[11:7];
        dec.funct3 = dec.illegal ? 3'b000 : ir[14:12];
    end

    assign idex_d = flush_e ? idex_t'('0) : dec;

    always_ff @(posedge clk) begin
        if (!rst) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign ID_EX_RD1        = idex_q.rd1;
    assign ID_EX_RD2        = idex_q.rd2;
    assign ID_EX_Imm        = idex_q.imm;
    assign ID_EX_PC         = idex_q.pc;
    assign ID_EX_Rs1        = idex_q.rs1;
    assign ID_EX_Rs2        = idex_q.rs2;
    assign ID_EX_Rd         = idex_q.rd;
    assign ID_EX_RegWrite   = idex_q.reg_write;
    assign ID_EX_MemWrite   = idex_q.mem_write;
    assign ID_EX_Jump       = idex_q.jump;
    assign ID_EX_Branch     = idex_q.branch;
    assign ID_EX_ALUSrc     = idex_q.alu_src;
    assign ID_EX_Jalr       = idex_q.jalr;
    assign ID_EX_ResultSrc  = idex_q.result_src;
    assign ID_EX_ALUControl = idex_q.alu_ctrl;
    assign ID_EX_Funct3     = idex_q.funct3;
    assign ID_EX_SrcAPC     = idex_q.src_a_pc;
    assign illegal_e        = idex_q.illegal;

endmodule

// File: tb/tb_instruction_decode.sv
// Scoreboard bench for instruction_decode: expected ID/EX contents queued at drive time,
// popped and compared one cycle later.
module tb_instruction_decode;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] IF_ID_IR = '0;
    logic [31:0] IF_ID_PC = '0;
    logic        flush_e = 1'b0;
    logic        RegWriteW = 1'b0;
    logic [4:0]  RdW = '0;
    logic [31:0] ResultW = '0;
    logic [31:0] ID_EX_RD1, ID_EX_RD2, ID_EX_Imm, ID_EX_PC;
    logic [4:0]  ID_EX_Rs1, ID_EX_Rs2, ID_EX_Rd;
    logic        ID_EX_RegWrite, ID_EX_MemWrite, ID_EX_Jump, ID_EX_Branch;
    logic        ID_EX_ALUSrc, ID_EX_Jalr, ID_EX_SrcAPC, illegal_e;
    logic [1:0]  ID_EX_ResultSrc;
    logic [3:0]  ID_EX_ALUControl;
    logic [2:0]  ID_EX_Funct3;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [16:0] ctl;
    } exp_t;

    exp_t sb_q[$];

    localparam logic [31:0] DB = 32'hDEADBEEF;

    always #5 clk = ~clk;

    instruction_decode dut (
        .clk              (clk),
        .rst              (rst),
        .IF_ID_IR         (IF_ID_IR),
        .IF_ID_PC         (IF_ID_PC),
        .flush_e          (flush_e),
        .RegWriteW        (RegWriteW),
        .RdW              (RdW),
        .ResultW          (ResultW),
        .ID_EX_RD1        (ID_EX_RD1),
        .ID_EX_RD2        (ID_EX_RD2),
        .ID_EX_Imm        (ID_EX_Imm),
        .ID_EX_PC         (ID_EX_PC),
        .ID_EX_Rs1        (ID_EX_Rs1),
        .ID_EX_Rs2        (ID_EX_Rs2),
        .ID_EX_Rd         (ID_EX_Rd),
        .ID_EX_RegWrite   (ID_EX_RegWrite),
        .ID_EX_MemWrite   (ID_EX_MemWrite),
        .ID_EX_Jump       (ID_EX_Jump),
        .ID_EX_Branch     (ID_EX_Branch),
        .ID_EX_ALUSrc     (ID_EX_ALUSrc),
        .ID_EX_Jalr       (ID_EX_Jalr),
        .ID_EX_ResultSrc  (ID_EX_ResultSrc),
        .ID_EX_ALUControl (ID_EX_ALUControl),
        .ID_EX_Funct3     (ID_EX_Funct3),
        .ID_EX_SrcAPC     (ID_EX_SrcAPC),
        .illegal_e        (illegal_e)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    // Control vector order: RegWrite MemWrite Jump Branch ALUSrc Jalr ResultSrc ALUControl Funct3 SrcAPC illegal
    function automatic logic [16:0] ctl(input logic rw, input logic mw, input logic j,
                                        input logic b, input logic as, input logic jr,
                                        input logic [1:0] rs, input logic [3:0] alu,
                                        input logic [2:0] f3, input logic apc, input logic ill);
        return {rw, mw, j, b, as, jr, rs, alu, f3, apc, ill};
    endfunction

    function automatic exp_t mk(input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic [31:0] imm, input logic [31:0] pc,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [16:0] c);
        exp_t e;
        e.rd1 = rd1; e.rd2 = rd2; e.imm = imm; e.pc = pc;
        e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.ctl = c;
        return e;
    endfunction

    task automatic step(input string name, input logic r, input logic fl, input logic we,
                        input logic [4:0] rdw, input logic [31:0] resw,
                        input logic [31:0] ir, input logic [31:0] pc, input exp_t e);
        exp_t x;
        logic [16:0] obs_ctl;
        @(negedge clk);
        rst       = r;
        flush_e   = fl;
        RegWriteW = we;
        RdW       = rdw;
        ResultW   = resw;
        IF_ID_IR  = ir;
        IF_ID_PC  = pc;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        x = sb_q.pop_front();
        obs_ctl = {ID_EX_RegWrite, ID_EX_MemWrite, ID_EX_Jump, ID_EX_Branch, ID_EX_ALUSrc,
                   ID_EX_Jalr, ID_EX_ResultSrc, ID_EX_ALUControl, ID_EX_Funct3,
                   ID_EX_SrcAPC, illegal_e};
        chk({name, ".rd1"}, ID_EX_RD1, x.rd1);
        chk({name, ".rd2"}, ID_EX_RD2, x.rd2);
        chk({name, ".imm"}, ID_EX_Imm, x.imm);
        chk({name, ".pc"},  ID_EX_PC,  x.pc);
        chk({name, ".rs1"}, {27'd0, ID_EX_Rs1}, {27'd0, x.rs1});
        chk({name, ".rs2"}, {27'd0, ID_EX_Rs2}, {27'd0, x.rs2});
        chk({name, ".rd"},  {27'd0, ID_EX_Rd},  {27'd0, x.rd});
        chk({name, ".ctl"}, {15'd0, obs_ctl},   {15'd0, x.ctl});
    endtask

    initial begin
        logic [16:0] c_add;
        logic [16:0] c_jal;
        c_add = ctl(1, 0, 0, 0, 0, 0, 2'b00, 4'd0, 3'd0, 0, 0);
        c_jal = ctl(1, 0, 1, 0, 0, 0, 2'b10, 4'd0, 3'd0, 0, 0);

        step("rst0", 0, 0, 0, 5'd0, 32'h0, 32'h003180B3, 32'h0, '0);
        step("rst1", 0, 0, 0, 5'd0, 32'h0, 32'h003180B3, 32'h0, '0);
        step("addi", 1, 0, 0, 5'd0, 32'h0, 32'hFFD00293, 32'h10,
             mk(0, 0, 32'hFFFFFFFD, 32'h10, 5'd0, 5'd29, 5'd5,
                ctl(1, 0, 0, 0, 1, 0, 2'b00, 4'd0, 3'd0, 0, 0)));
        step("wthru", 1, 0, 1, 5'd3, DB, 32'h003180B3, 32'h14,
             mk(DB, DB, 0, 32'h14, 5'd3, 5'd3, 5'd1, c_add));
        step("rfread", 1, 0, 0, 5'd0, 32'h0, 32'h003180B3, 32'h18,
             mk(DB, DB, 0, 32'h18, 5'd3, 5'd3, 5'd1, c_add));
        step("x0", 1, 0, 1, 5'd0, 32'd5, 32'h000000B3, 32'h1C,
             mk(0, 0, 0, 32'h1C, 5'd0, 5'd0, 5'd1, c_add));
        step("beq", 1, 0, 0, 5'd0, 32'h0, 32'hFE208CE3, 32'h20,
             mk(0, 0, 32'hFFFFFFF8, 32'h20, 5'd1, 5'd2, 5'd25,
                ctl(0, 0, 0, 1, 0, 0, 2'b00, 4'd1, 3'd0, 0, 0)));
        step("flush", 1, 1, 0, 5'd0, 32'h0, 32'hFFD00293, 32'h24, '0);
        step("illegal", 1, 0, 0, 5'd0, 32'h0, 32'h0000007F, 32'h40,
             mk(0, 0, 0, 32'h40, 5'd0, 5'd0, 5'd0,
                ctl(0, 0, 0, 0, 0, 0, 2'b00, 4'd0, 3'd0, 0, 1)));
        step("lw", 1, 0, 0, 5'd0, 32'h0, 32'h0081A303, 32'h44,
             mk(DB, 0, 32'h8, 32'h44, 5'd3, 5'd8, 5'd6,
                ctl(1, 0, 0, 0, 1, 0, 2'b01, 4'd0, 3'd2, 0, 0)));
        step("sw", 1, 0, 0, 5'd0, 32'h0, 32'hFE51AE23, 32'h48,
             mk(DB, 0, 32'hFFFFFFFC, 32'h48, 5'd3, 5'd5, 5'd28,
                ctl(0, 1, 0, 0, 1, 0, 2'b00, 4'd0, 3'd2, 0, 0)));
        step("jal", 1, 0, 0, 5'd0, 32'h0, 32'h001000EF, 32'h4C,
             mk(0, 0, 32'h800, 32'h4C, 5'd0, 5'd1, 5'd1, c_jal));
        step("jalneg", 1, 0, 0, 5'd0, 32'h0, 32'hFFDFF06F, 32'h50,
             mk(0, 0, 32'hFFFFFFFC, 32'h50, 5'd31, 5'd29, 5'd0,
                ctl(1, 0, 1, 0, 0, 0, 2'b10, 4'd0, 3'd7, 0, 0)));
        step("jalr", 1, 0, 0, 5'd0, 32'h0, 32'h00C08067, 32'h54,
             mk(0, 0, 32'hC, 32'h54, 5'd1, 5'd12, 5'd0,
                ctl(1, 0, 1, 0, 1, 1, 2'b10, 4'd0, 3'd0, 0, 0)));
        step("lui", 1, 0, 0, 5'd0, 32'h0, 32'h123453B7, 32'h58,
             mk(0, DB, 32'h12345000, 32'h58, 5'd8, 5'd3, 5'd7,
                ctl(1, 0, 0, 0, 1, 0, 2'b00, 4'd10, 3'd5, 0, 0)));
        step("auipc", 1, 0, 0, 5'd0, 32'h0, 32'hFFFFF417, 32'h5C,
             mk(0, 0, 32'hFFFFF000, 32'h5C, 5'd31, 5'd31, 5'd8,
                ctl(1, 0, 0, 0, 1, 0, 2'b00, 4'd0, 3'd7, 1, 0)));
        step("sub", 1, 0, 0, 5'd0, 32'h0, 32'h40318233, 32'h60,
             mk(DB, DB, 0, 32'h60, 5'd3, 5'd3, 5'd4,
                ctl(1, 0, 0, 0, 0, 0, 2'b00, 4'd1, 3'd0, 0, 0)));
        step("srai", 1, 0, 0, 5'd0, 32'h0, 32'h4041D493, 32'h64,
             mk(DB, 0, 32'h404, 32'h64, 5'd3, 5'd4, 5'd9,
                ctl(1, 0, 0, 0, 1, 0, 2'b00, 4'd9, 3'd5, 0, 0)));
        step("addi_b30", 1, 0, 0, 5'd0, 32'h0, 32'h40018493, 32'h68,
             mk(DB, 0, 32'h400, 32'h68, 5'd3, 5'd0, 5'd9,
                ctl(1, 0, 0, 0, 1, 0, 2'b00, 4'd0, 3'd0, 0, 0)));
        step("or", 1, 0, 0, 5'd0, 32'h0, 32'h0031E5B3, 32'h6C,
             mk(DB, DB, 0, 32'h6C, 5'd3, 5'd3, 5'd11,
                ctl(1, 0, 0, 0, 0, 0, 2'b00, 4'd3, 3'd6, 0, 0)));
        step("rst_mid", 0, 1, 1, 5'd3, 32'h1, 32'hFFD00293, 32'h70, '0);
        step("post_rst", 1, 0, 0, 5'd0, 32'h0, 32'h003180B3, 32'h74,
             mk(0, 0, 0, 32'h74, 5'd3, 5'd3, 5'd1, c_add));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
